address_map_pipe: RTL

- Registered, parametrised successor to the combinational SNES address decoder.
- Runtime mapper-mode select: HiROM, LoROM, or GSU hybrid.
- PIPE_STAGES-deep output pipeline and NUM_WIN MCU-programmable MMIO match windows.
- SaveRAM write tracking (dirty flag, saturating write counter, last-address latch) with an MCU clear handshake.
- Sits between SNES bus sampling and the SRAM0 arbiter / peripheral enables.

---
 rtl/address_map_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/address_map_pipe.sv
// SNES address decoder: runtime HiROM/LoROM/GSU mapping, MMIO match windows, SaveRAM write tracking.
// Optional build macro SAVERAM_WP_EN adds the saveram_wp write-protect input.
module address_map_pipe #(
  parameter int PIPE_STAGES = 1,
  parameter int NUM_WIN     = 4,
  parameter int CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2:0]         MAPPER,
  input  logic [23:0]        SNES_ADDR,
  input  logic               SNES_ROMSEL,
  input  logic [23:0]        SAVERAM_MASK,
  input  logic [23:0]        ROM_MASK,
  input  logic               snes_wr_end,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [23:0]        cfg_base,
  input  logic [23:0]        cfg_mask,
  input  logic               cfg_en,
  input  logic               dirty_clr,
`ifdef SAVERAM_WP_EN
  input  logic               saveram_wp,
`endif
  output logic [23:0]        ROM_ADDR,
  output logic               ROM_HIT,
  output logic               IS_ROM,
  output logic               IS_SAVERAM,
  output logic               IS_WRITABLE,
  output logic [NUM_WIN-1:0] win_hit,
  output logic               dirty,
  output logic [CNT_W-1:0]   wr_count,
  output logic [23:0]        last_wr_addr
);

  typedef struct packed {
    logic [23:0]        rom_addr;
    logic               is_rom;
    logic               is_saveram;
    logic               is_writable;
    logic [NUM_WIN-1:0] win;
  } dec_t;

  logic [23:0] win_base [NUM_WIN];
  logic [23:0] win_mask [NUM_WIN];
  logic [NUM_WIN-1:0] win_en;

  logic wp;
`ifdef SAVERAM_WP_EN
  assign wp = saveram_wp;
`else
  assign wp = 1'b0;
`endif

  logic a22, a21, a15, a14, a13, romsel;
  assign a22    = SNES_ADDR[22];
  assign a21    = SNES_ADDR[21];
  assign a15    = SNES_ADDR[15];
  assign a14    = SNES_ADDR[14];
  assign a13    = SNES_ADDR[13];
  assign romsel = SNES_ROMSEL;

  logic        gsu_rom, gsu_sr, hi_rom, hi_sr, lo_rom, lo_sr, lo_region;
  logic [23:0] gsu_sr_off, hi_sr_off, lo_sr_off;
  logic [23:0] gsu_rom_addr, hi_rom_addr, lo_rom_addr;
  dec_t        dec;

  always_comb begin
    gsu_rom      = (~a22 & a15) | (a22 & ~romsel);
    gsu_sr       = SAVERAM_MASK[0] & ((a22 & a21 & ~romsel) | (~a22 & ~a15 & a14 & a13));
    gsu_sr_off   = (a22 ? {7'b0, SNES_ADDR[16:0]} : {11'b0, SNES_ADDR[12:0]}) & SAVERAM_MASK;
    gsu_rom_addr = (a22 ? {2'b0, SNES_ADDR[21:0]}
                        : {2'b0, SNES_ADDR[22:16], SNES_ADDR[14:0]}) & ROM_MASK;

    hi_rom       = ~romsel | a22;
    hi_sr        = SAVERAM_MASK[0] & ~a22 & a21 & ~a15 & a14 & a13;
    hi_sr_off    = {6'b0, SNES_ADDR[20:16], SNES_ADDR[12:0]} & SAVERAM_MASK;
    hi_rom_addr  = {2'b0, SNES_ADDR[21:0]} & ROM_MASK;

    // banks 70-7D and F0-FF, lower half of the bank
    lo_region    = ~romsel & (&SNES_ADDR[22:20])
                   & (SNES_ADDR[23] | (SNES_ADDR[19:16] < 4'hE)) & ~a15;
    lo_sr        = SAVERAM_MASK[0] & lo_region;
    lo_rom       = a15 & ~lo_region;
    lo_sr_off    = {5'b0, SNES_ADDR[19:16], SNES_ADDR[14:0]} & SAVERAM_MASK;
    lo_rom_addr  = {2'b0, SNES_ADDR[22:16], SNES_ADDR[14:0]} & ROM_MASK;

    dec = '0;
    case (MAPPER)
      3'b000: begin
        dec.is_rom     = hi_rom;
        dec.is_saveram = hi_sr;
        dec.rom_addr   = hi_sr ? 24'hE00000 + hi_sr_off : hi_rom_addr;
      end
      3'b001: begin
        dec.is_rom     = lo_rom;
        dec.is_saveram = lo_sr;
        dec.rom_addr   = lo_sr ? 24'hE00000 + lo_sr_off : lo_rom_addr;
      end
      default: begin
        dec.is_rom     = gsu_rom;
        dec.is_saveram = gsu_sr;
        dec.rom_addr   = gsu_sr ? 24'hE00000 + gsu_sr_off : gsu_rom_addr;
      end
    endcase
    dec.is_writable = dec.is_saveram & ~wp;
    for (int i = 0; i < NUM_WIN; i++) begin
      dec.win[i] = win_en[i] & ((SNES_ADDR & win_mask[i]) == (win_base[i] & win_mask[i]));
    end
  end

  // Indices at or above NUM_WIN match no loop iteration and are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      win_en <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        win_base[i] <= '0;
        win_mask[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (cfg_idx == 3'(i)) begin
          win_base[i] <= cfg_base;
          win_mask[i] <= cfg_mask;
          win_en[i]   <= cfg_en;
        end
      end
    end
  end

  dec_t pipe [PIPE_STAGES];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < PIPE_STAGES; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= dec;
      for (int s = 1; s < PIPE_STAGES; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign ROM_ADDR    = pipe[PIPE_STAGES-1].rom_addr;
  assign IS_ROM      = pipe[PIPE_STAGES-1].is_rom;
  assign IS_SAVERAM  = pipe[PIPE_STAGES-1].is_saveram;
  assign IS_WRITABLE = pipe[PIPE_STAGES-1].is_writable;
  assign win_hit     = pipe[PIPE_STAGES-1].win;
  assign ROM_HIT     = IS_ROM | IS_WRITABLE;

  logic counted;
  assign counted = snes_wr_end & IS_WRITABLE;

  // A counted write takes priority over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dirty        <= 1'b0;
      wr_count     <= '0;
      last_wr_addr <= '0;
    end else if (counted) begin
      dirty        <= 1'b1;
      last_wr_addr <= ROM_ADDR;
      if (dirty_clr)      wr_count <= CNT_W'(1);
      else if (~&wr_count) wr_count <= wr_count + CNT_W'(1);
    end else if (dirty_clr) begin
      dirty    <= 1'b0;
      wr_count <= '0;
    end
  end

endmodule
